// File: rtl/nibble_scan_mux_if.sv
// Data, control and display signals of the nibble scanner.
// The master side drives the inputs; the scanner attaches to the slave side.
interface nibble_scan_mux_if #(
  parameter int unsigned NIBBLES = 8,
  localparam int unsigned SELW   = $clog2(NIBBLES)
);
  logic [4*NIBBLES-1:0] datain;
  logic                 auto;
  logic [SELW-1:0]      sel;
  logic [NIBBLES-1:0]   blank;
  logic [3:0]           y;
  logic [NIBBLES-1:0]   an;
  logic [SELW-1:0]      idx;
  logic                 frame;

  modport master (
    output datain, auto, sel, blank,
    input  y, an, idx, frame
  );

  modport slave (
    input  datain, auto, sel, blank,
    output y, an, idx, frame
  );
endinterface

// File: rtl/nibble_scan_mux.sv
// Registered nibble selector and multiplexed display scanner with a frame-latched
// shadow copy of the input word, so a scan frame never mixes old and new data.
module nibble_scan_mux #(
  parameter int unsigned NIBBLES = 8,
  parameter int unsigned DIV     = 50000,
  localparam int unsigned SELW   = $clog2(NIBBLES),
  localparam int unsigned PW     = (DIV > 1) ? $clog2(DIV) : 1
) (
  input logic              clk,
  input logic              rst,
  nibble_scan_mux_if.slave bus
);

  localparam logic [NIBBLES-1:0] OneHot0 = {{(NIBBLES-1){1'b0}}, 1'b1};

  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [SELW-1:0]        idx_q, idx_d;
  logic [4*NIBBLES-1:0]   shadow_q, shadow_d;
  logic [3:0]             y_q, y_d;
  logic [NIBBLES-1:0]     an_q, an_d;
  logic                   frame_q, frame_d;
  logic                   first_q;

  logic                   tick;
  logic                   last;
  logic [SELW-1:0]        sel_c;
  logic [4*NIBBLES-1:0]   src;

  always_comb begin
    tick     = (pcnt_q == PW'(DIV - 1));
    last     = (idx_q == SELW'(NIBBLES - 1));
    // Out-of-range manual indices fall back to nibble 0.
    sel_c    = ({1'b0, bus.sel} >= (SELW + 1)'(NIBBLES)) ? '0 : bus.sel;
    pcnt_d   = '0;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    src      = shadow_q;

    if (bus.auto) begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
      if (tick) begin
        idx_d = last ? '0 : idx_q + SELW'(1);
      end
      frame_d = first_q || (tick && last);
      // A frame start reads the incoming word directly to avoid a cycle of lag.
      if (frame_d) begin
        shadow_d = bus.datain;
        src      = bus.datain;
      end
    end else begin
      idx_d    = sel_c;
      shadow_d = bus.datain;
      src      = bus.datain;
    end

    y_d  = src[idx_d*4 +: 4];
    an_d = bus.blank[idx_d] ? '1 : ~(OneHot0 << idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      an_q     <= '1;
      frame_q  <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
      first_q  <= 1'b0;
    end
  end

  assign bus.y     = y_q;
  assign bus.an    = an_q;
  assign bus.idx   = idx_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_nibble_scan_mux.sv
// Randomized bench for nibble_scan_mux (8 nibbles, DIV=4) plus a 6-nibble instance
// exercising out-of-range manual selects.
module tb_nibble_scan_mux;

  localparam int unsigned N   = 8;
  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_scan_mux_if #(.NIBBLES(8)) bus8 ();
  nibble_scan_mux_if #(.NIBBLES(6)) bus6 ();

  nibble_scan_mux #(.NIBBLES(8), .DIV(DIV)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  nibble_scan_mux #(.NIBBLES(6), .DIV(DIV)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: dwell counter, digit index, latched frame word.
  int          m_cnt;
  int          m_idx;
  logic [31:0] m_word;
  bit          m_first;
  logic [3:0]  e_y;
  logic [7:0]  e_an;
  int          e_idx;
  bit          e_frame;
  bit          chk6;
  logic [3:0]  e6_y;
  int          e6_idx;
  logic [5:0]  e6_an;

  function automatic void model_reset();
    m_cnt = 0; m_idx = 0; m_word = '0; m_first = 1'b1;
  endfunction

  function automatic void model_edge();
    int  nxt;
    bit  start;
    if (bus8.auto) begin
      m_cnt++;
      nxt = m_idx;
      start = m_first;
      if (m_cnt == DIV) begin
        m_cnt = 0;
        nxt = (m_idx + 1) % N;
        if (nxt == 0) start = 1'b1;
      end
      if (start) m_word = bus8.datain;
      e_frame = start;
    end else begin
      m_cnt   = 0;
      nxt     = int'(bus8.sel);
      m_word  = bus8.datain;
      e_frame = 1'b0;
    end
    m_first = 1'b0;
    m_idx   = nxt;
    e_idx   = nxt;
    e_y     = m_word[4*nxt +: 4];
    e_an    = bus8.blank[nxt] ? 8'hFF : ~(8'h01 << nxt);
    // Six-digit instance runs in manual mode only.
    e6_idx  = (int'(bus6.sel) >= 6) ? 0 : int'(bus6.sel);
    e6_y    = bus6.datain[4*e6_idx +: 4];
    e6_an   = bus6.blank[e6_idx] ? 6'h3F : ~(6'h01 << e6_idx);
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("y", 32'(bus8.y), 32'(e_y));
    check("an", 32'(bus8.an), 32'(e_an));
    check("idx", 32'(bus8.idx), e_idx);
    check("frame", 32'(bus8.frame), 32'(e_frame));
    if (chk6) begin
      check("y6", 32'(bus6.y), 32'(e6_y));
      check("idx6", 32'(bus6.idx), e6_idx);
      check("an6", 32'(bus6.an), 32'(e6_an));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_y"}, 32'(bus8.y), 32'h0);
    check({tag, "_an"}, 32'(bus8.an), 32'hFF);
    check({tag, "_frame"}, 32'(bus8.frame), 32'h0);
    check({tag, "_idx"}, 32'(bus8.idx), 32'h0);
  endtask

  initial begin
    bit seen;
    chk6 = 1'b0;
    bus8.datain = 32'h7654_3210; bus8.auto = 1'b1; bus8.sel = '0; bus8.blank = '0;
    bus6.datain = 24'h0;         bus6.auto = 1'b0; bus6.sel = '0; bus6.blank = '0;
    model_reset();

    // Reset and start of scan.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    step();
    check("start_idx", 32'(bus8.idx), 32'h0);
    check("start_y", 32'(bus8.y), 32'h0);
    check("start_an", 32'(bus8.an), 32'hFE);
    check("start_frame", 32'(bus8.frame), 32'h1);

    // Full frame of auto scanning; y tracks idx for this data word.
    for (int i = 0; i < 33; i++) begin
      step();
      check("scan_y_eq_idx", 32'(bus8.y), 32'(bus8.idx));
    end

    // Tear-free: new word at idx 3 must not show until the wrap.
    seen = 1'b0;
    for (int i = 0; i < 64 && bus8.idx != 3'd3; i++) step();
    bus8.datain = 32'hFFFF_FFFF;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      if (bus8.frame) seen = 1'b1;
      else check("tear_old_y", 32'(bus8.y), 32'(bus8.idx));
    end
    check("wrap_seen", 32'(seen), 32'h1);
    check("wrap_y", 32'(bus8.y), 32'hF);
    check("wrap_idx", 32'(bus8.idx), 32'h0);

    // Manual select.
    bus8.auto = 1'b0; bus8.datain = 32'hCAFE_BABE; bus8.sel = 3'd5;
    step();
    check("man_y", 32'(bus8.y), 32'hF);
    check("man_idx", 32'(bus8.idx), 32'h5);
    check("man_an", 32'(bus8.an), 32'hDF);
    check("man_frame", 32'(bus8.frame), 32'h0);

    // Blank mask and mode switches.
    bus8.auto = 1'b1; bus8.blank = 8'h04;
    for (int i = 0; i < 64 && bus8.idx != 3'd2; i++) step();
    check("blank_an", 32'(bus8.an), 32'hFF);
    step();
    bus8.auto = 1'b0; bus8.sel = 3'd6;
    step();
    check("sw_man_idx", 32'(bus8.idx), 32'h6);
    bus8.auto = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sw_dwell_idx", 32'(bus8.idx), 32'h6);
    end
    step();
    check("sw_step_idx", 32'(bus8.idx), 32'h7);
    bus8.blank = '0;

    // Six-digit instance: every sel including the out-of-range codes.
    chk6 = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus6.datain = 24'($urandom);
      bus6.sel    = 3'(s);
      step();
    end

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 600; i++) begin
      bus8.auto = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) bus8.sel = 3'($urandom);
      if ($urandom_range(0, 9) == 0) bus8.datain = $urandom;
      if ($urandom_range(0, 7) == 0) bus8.blank = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      bus6.sel    = 3'($urandom);
      bus6.datain = 24'($urandom);
      bus6.blank  = 6'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
